// File: rtl/multi_pulse_sync_rx.sv
`default_nettype none
// ============================================================================
//  Module      : multi_pulse_sync_rx
//  Description : Multi-channel toggle-event receiver. Each channel synchronizes
//                an asynchronous toggle level, turns each level change into an
//                event and keeps a saturating pending count with valid/ready
//                drain and a sticky overflow flag.
//                Optional: MULTI_PULSE_SYNC_RX_RAW_PULSE_EN enables dest_pulse.
//  Revision    : 1.0 - initial release
// ============================================================================
module multi_pulse_sync_rx #(
    parameter int NUM_CH      = 4,
    parameter int SYNC_STAGES = 2,
    parameter int CNT_W       = 3
) (
    input  logic                    clk_dest,
    input  logic                    rst_dest,
    input  logic [NUM_CH-1:0]       src_tgl,
    output logic [NUM_CH-1:0]       dest_valid,
    input  logic [NUM_CH-1:0]       dest_ready,
    output logic [NUM_CH*CNT_W-1:0] dest_pend,
    output logic [NUM_CH-1:0]       dest_ovf,
    input  logic [NUM_CH-1:0]       ovf_clr,
    output logic [NUM_CH-1:0]       dest_pulse
);

    localparam int                  c_warm_w    = $clog2(SYNC_STAGES + 2);
    localparam logic [c_warm_w-1:0] c_warm_done = c_warm_w'(SYNC_STAGES + 1);

    logic [NUM_CH-1:0]   r_sync [SYNC_STAGES];
    logic [NUM_CH-1:0]   r_lvl_q;
    logic [c_warm_w-1:0] r_warm;
    logic                w_warm_done;
    logic [NUM_CH-1:0]   w_event;

    always_ff @(posedge clk_dest) begin
        if (rst_dest) begin
            for (int s = 0; s < SYNC_STAGES; s++) begin
                r_sync[s] <= '0;
            end
            r_lvl_q <= '0;
        end else begin
            r_sync[0] <= src_tgl;
            for (int s = 1; s < SYNC_STAGES; s++) begin
                r_sync[s] <= r_sync[s-1];
            end
            r_lvl_q <= r_sync[SYNC_STAGES-1];
        end
    end

    // Hold off detection until the chain has flushed, so a level already
    // present at reset release is absorbed rather than counted.
    always_ff @(posedge clk_dest) begin
        if (rst_dest) begin
            r_warm <= '0;
        end else if (!w_warm_done) begin
            r_warm <= r_warm + c_warm_w'(1);
        end
    end

    assign w_warm_done = (r_warm == c_warm_done);
    assign w_event     = (r_sync[SYNC_STAGES-1] ^ r_lvl_q) & {NUM_CH{w_warm_done}};

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        localparam logic [CNT_W-1:0] c_cnt_max = '1;

        logic [CNT_W-1:0] r_cnt;
        logic             r_ovf;
        logic             w_xfer;

        assign w_xfer = (r_cnt != '0) && dest_ready[i];

        always_ff @(posedge clk_dest) begin
            if (rst_dest) begin
                r_cnt <= '0;
                r_ovf <= 1'b0;
            end else begin
                if (w_event[i] && !w_xfer) begin
                    if (r_cnt != c_cnt_max) begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end else if (!w_event[i] && w_xfer) begin
                    r_cnt <= r_cnt - CNT_W'(1);
                end

                // Set wins over clear when both land in the same cycle.
                if (w_event[i] && !w_xfer && (r_cnt == c_cnt_max)) begin
                    r_ovf <= 1'b1;
                end else if (ovf_clr[i]) begin
                    r_ovf <= 1'b0;
                end
            end
        end

        assign dest_pend[i*CNT_W +: CNT_W] = r_cnt;
        assign dest_valid[i]               = (r_cnt != '0);
        assign dest_ovf[i]                 = r_ovf;
    end

`ifdef MULTI_PULSE_SYNC_RX_RAW_PULSE_EN
    logic [NUM_CH-1:0] r_pulse;

    always_ff @(posedge clk_dest) begin
        if (rst_dest) begin
            r_pulse <= '0;
        end else begin
            r_pulse <= w_event;
        end
    end

    assign dest_pulse = r_pulse;
`else
    assign dest_pulse = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_multi_pulse_sync_rx.sv
`default_nettype none
// ============================================================================
//  Module      : tb_multi_pulse_sync_rx
//  Description : Self-checking bench for multi_pulse_sync_rx against an
//                event-schedule reference model (directed + random stimulus).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_multi_pulse_sync_rx;

    localparam int NUM_CH = 4;
    localparam int SS     = 2;
    localparam int CNT_W  = 3;
    localparam int c_max  = (1 << CNT_W) - 1;

    logic                    clk_dest = 1'b0;
    logic                    rst_dest = 1'b1;
    logic [NUM_CH-1:0]       src_tgl  = '0;
    logic [NUM_CH-1:0]       dest_ready = '0;
    logic [NUM_CH-1:0]       ovf_clr  = '0;
    logic [NUM_CH-1:0]       dest_valid;
    logic [NUM_CH*CNT_W-1:0] dest_pend;
    logic [NUM_CH-1:0]       dest_ovf;
    logic [NUM_CH-1:0]       dest_pulse;

    multi_pulse_sync_rx #(
        .NUM_CH     (NUM_CH),
        .SYNC_STAGES(SS),
        .CNT_W      (CNT_W)
    ) u_dut (
        .clk_dest  (clk_dest),
        .rst_dest  (rst_dest),
        .src_tgl   (src_tgl),
        .dest_valid(dest_valid),
        .dest_ready(dest_ready),
        .dest_pend (dest_pend),
        .dest_ovf  (dest_ovf),
        .ovf_clr   (ovf_clr),
        .dest_pulse(dest_pulse)
    );

    always #5 clk_dest = ~clk_dest;

    int n_checks = 0;
    int n_errors = 0;
    int cyc      = 0;
    int warm_end = 0;
    int m_cnt    [NUM_CH];
    bit m_ovf    [NUM_CH];
    bit m_pulse  [NUM_CH];
    int last_tgl [NUM_CH];
    bit m_sched  [16][NUM_CH];   // event landing edge (mod 16) per channel

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    // Drive one cycle of inputs, advance one edge, update the model, compare.
    task automatic step(input logic [NUM_CH-1:0] tgl, input logic [NUM_CH-1:0] rdy,
                        input logic [NUM_CH-1:0] clr, input bit rst);
        logic [NUM_CH*CNT_W-1:0] e_pend;
        logic [NUM_CH-1:0]       e_valid, e_ovf, e_pulse;
        bit                      ev, xfer;
        src_tgl = src_tgl ^ tgl;
        for (int ch = 0; ch < NUM_CH; ch++) begin
            if (tgl[ch]) begin
                m_sched[(cyc + SS + 1) % 16][ch] = 1'b1;
                last_tgl[ch] = cyc;
            end
        end
        dest_ready = rdy;
        ovf_clr    = clr;
        rst_dest   = rst;
        @(posedge clk_dest);
        #1;
        cyc++;
        if (rst) begin
            for (int ch = 0; ch < NUM_CH; ch++) begin
                m_cnt[ch] = 0; m_ovf[ch] = 1'b0; m_pulse[ch] = 1'b0;
                for (int k = 0; k < 16; k++) m_sched[k][ch] = 1'b0;
            end
            warm_end = cyc + SS + 1;
        end else begin
            for (int ch = 0; ch < NUM_CH; ch++) begin
                ev   = m_sched[cyc % 16][ch] && (cyc > warm_end);
                m_sched[cyc % 16][ch] = 1'b0;
                xfer = rdy[ch] && (m_cnt[ch] > 0);
                if (ev && !xfer && m_cnt[ch] == c_max) m_ovf[ch] = 1'b1;
                else if (clr[ch])                      m_ovf[ch] = 1'b0;
                if (ev && !xfer && m_cnt[ch] < c_max) m_cnt[ch]++;
                else if (xfer && !ev)                 m_cnt[ch]--;
                m_pulse[ch] = ev;
            end
        end
        for (int ch = 0; ch < NUM_CH; ch++) begin
            e_pend[ch*CNT_W +: CNT_W] = CNT_W'(m_cnt[ch]);
            e_valid[ch] = (m_cnt[ch] != 0);
            e_ovf[ch]   = m_ovf[ch];
`ifdef MULTI_PULSE_SYNC_RX_RAW_PULSE_EN
            e_pulse[ch] = m_pulse[ch];
`else
            e_pulse[ch] = 1'b0;
`endif
        end
        check("dest_pend",  32'(dest_pend),  32'(e_pend));
        check("dest_valid", 32'(dest_valid), 32'(e_valid));
        check("dest_ovf",   32'(dest_ovf),   32'(e_ovf));
        check("dest_pulse", 32'(dest_pulse), 32'(e_pulse));
    endtask

    task automatic idle(input int n);
        repeat (n) step('0, '0, '0, 1'b0);
    endtask

    initial begin
        logic [NUM_CH-1:0] t, r, c;
        bit                rs;
        for (int ch = 0; ch < NUM_CH; ch++) begin
            m_cnt[ch] = 0; m_ovf[ch] = 1'b0; m_pulse[ch] = 1'b0; last_tgl[ch] = -100;
            for (int k = 0; k < 16; k++) m_sched[k][ch] = 1'b0;
        end

        repeat (3) step('0, '0, '0, 1'b1);
        idle(4);

        // Single toggle on channel 0, nothing consumed.
        step(4'b0001, '0, '0, 1'b0);
        idle(5);

        // Channel 1: nine events saturate the counter, then clear overflow.
        repeat (9) begin
            step(4'b0010, '0, '0, 1'b0);
            idle(3);
        end
        idle(3);
        step('0, '0, 4'b0010, 1'b0);
        idle(2);

        // Channel 2: transfer and new event land on the same edge.
        step(4'b0100, '0, '0, 1'b0);
        idle(4);
        step(4'b0100, '0, '0, 1'b0);
        step('0, '0, '0, 1'b0);
        step('0, 4'b0100, '0, 1'b0);
        idle(2);
        step('0, 4'b0100, '0, 1'b0);
        idle(1);

        // Channel 0 up to 5 pending, then a single-cycle reset.
        repeat (4) begin
            step(4'b0001, '0, '0, 1'b0);
            idle(3);
        end
        idle(2);
        step('0, '0, '0, 1'b1);
        idle(6);

        // All-ones level held through reset and release must not count.
        step(~src_tgl, '0, '0, 1'b1);
        step('0, '0, '0, 1'b1);
        idle(10);

        // Random traffic: sparse consumption first (overflows), dense later.
        for (int k = 0; k < 1500; k++) begin
            t = '0;
            for (int ch = 0; ch < NUM_CH; ch++) begin
                if ((cyc - last_tgl[ch] >= SS + 1) && ($urandom_range(0, 2) == 0)) t[ch] = 1'b1;
            end
            r  = (k < 750) ? NUM_CH'($urandom & $urandom & $urandom) : NUM_CH'($urandom);
            c  = ($urandom_range(0, 15) == 0) ? NUM_CH'($urandom) : '0;
            rs = ($urandom_range(0, 199) == 0);
            if (rs) t = '0;
            step(t, r, c, rs);
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not complete (cycle %0d)", cyc);
        $fatal(1);
    end

endmodule
`default_nettype wire

// File: doc/multi_pulse_sync_rx.md
MULTI_PULSE_SYNC_RX -- requirements
Module: multi_pulse_sync_rx

Interface
REQ-001 Parameter NUM_CH, default 4, SHALL set the number of independent channels (1..32).
REQ-002 Parameter SYNC_STAGES, default 2, SHALL set the synchronizer depth per channel (2..4).
REQ-003 Parameter CNT_W, default 3, SHALL set the pending-event counter width per channel (1..8).
REQ-004 clk_dest  input  1  SHALL be the single destination clock; all state is on its rising edge.
REQ-005 rst_dest  input  1  SHALL be the reset: synchronous, active-high.
REQ-006 src_tgl  input  NUM_CH  SHALL carry one asynchronous toggle level per channel; each level change is one event.
REQ-007 dest_valid  output  NUM_CH  SHALL be high per channel while that channel's pending count is nonzero.
REQ-008 dest_ready  input  NUM_CH  SHALL be the per-channel consumer accept.
REQ-009 dest_pend  output  NUM_CH*CNT_W  SHALL present each channel's pending count; channel i occupies bits [i*CNT_W +: CNT_W].
REQ-010 dest_ovf  output  NUM_CH  SHALL be a sticky per-channel overflow flag.
REQ-011 ovf_clr  input  NUM_CH  SHALL clear dest_ovf per channel.
REQ-012 dest_pulse  output  NUM_CH  SHALL be the raw one-cycle event strobe (see Configuration).

Function
REQ-013 Each src_tgl bit SHALL pass through a SYNC_STAGES-deep flop chain; a last-stage register lvl_q SHALL hold the previous synchronized level.
REQ-014 An event SHALL be detected on a channel when its last sync stage differs from lvl_q; lvl_q SHALL update every cycle.
REQ-015 Latency: the first clk_dest edge that samples a new src_tgl level is edge 1; dest_valid SHALL assert after edge SYNC_STAGES+1.
REQ-016 A transfer SHALL occur when dest_valid and dest_ready are both high on a channel; the pending count SHALL then decrement by 1.
REQ-017 dest_ready while dest_valid is low SHALL have no effect.
REQ-018 If an event and a transfer occur in the same cycle, the pending count SHALL stay unchanged.
REQ-019 If an event arrives with the count at 2^CNT_W-1 and no transfer occurs, the count SHALL stay saturated and dest_ovf SHALL set the next cycle.
REQ-020 ovf_clr SHALL clear dest_ovf the next cycle; simultaneous set and clear SHALL leave dest_ovf set.
REQ-021 Channels SHALL be fully independent; no event, transfer or overflow on one channel SHALL affect another.
REQ-022 Source toggles SHALL be at least SYNC_STAGES+1 clk_dest cycles apart per channel; faster toggles are outside the contract.

Reset
REQ-023 While rst_dest is high, the sync flops, lvl_q, pending counts and dest_ovf SHALL clear to 0, so dest_valid, dest_pend, dest_ovf and dest_pulse read 0 the cycle after.
REQ-024 Warm-up: events detected in the first SYNC_STAGES+1 cycles after rst_dest deasserts SHALL be discarded (no count, no pulse), so a static 1 on src_tgl is not counted.
REQ-025 Reset asserted mid-operation SHALL discard all pending events and overflow state without emitting transfers.

Configuration
REQ-026 With macro MULTI_PULSE_SYNC_RX_RAW_PULSE_EN defined, dest_pulse SHALL go high for exactly one cycle, in the cycle the count increments or is held at saturation, for each non-discarded event.
REQ-027 Without MULTI_PULSE_SYNC_RX_RAW_PULSE_EN, dest_pulse SHALL be tied to 0 and no raw-pulse logic SHALL be synthesized; all other behaviour SHALL be identical.

Verification
REQ-028 Defaults, dest_ready=0: toggle src_tgl[0] once -> dest_valid[0] high after edge 3, dest_pend[0]=1, other channels 0.
REQ-029 Defaults, dest_ready[1]=0: 9 toggles spaced 4 cycles apart -> dest_pend[1] saturates at 7, dest_ovf[1]=1; ovf_clr[1] pulse -> dest_ovf[1]=0, count stays 7.
REQ-030 dest_pend[2]=1 with dest_ready[2]=1 while a new event is detected -> dest_pend[2] stays 1 for that cycle.
REQ-031 src_tgl=4'hF held through reset and release -> dest_pend stays 0 on all channels, dest_pulse never asserts.
REQ-032 Macro defined, toggle channel 3 -> dest_pulse[3] high for exactly 1 cycle, aligned with dest_pend[3] going 0->1; macro undefined -> dest_pulse stays 0.
REQ-033 rst_dest pulsed for 1 cycle with dest_pend[0]=5 -> dest_pend[0]=0 and dest_valid[0]=0 on the following cycle.
